// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// master = fetch/decode side driving the queue, slave = the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_inst;
    logic             if_ready;
    logic             pc_stall;
    logic             flush;
    logic             id_valid;
    logic [31:0]      id_pc;
    logic [31:0]      id_inst;
    logic             id_ready;
    logic [PTR_W:0]   occupancy;

    modport master (
        output if_valid, if_pc, if_inst, flush, id_ready,
        input  if_ready, pc_stall, id_valid, id_pc, id_inst, occupancy
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush, id_ready,
        output if_ready, pc_stall, id_valid, id_pc, id_inst, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: DEPTH-entry circular buffer of {pc, inst}
// with valid/ready on both sides, PC stall when full and single-cycle flush.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  fq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Handshake: a transfer happens on an edge where valid and ready are both
    // high; flush cancels any transfer offered in the same cycle.
    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push, pop;
    logic             not_full, not_empty;

    assign not_full  = (count_q != FULL_CNT);
    assign not_empty = (count_q != '0);
    assign push      = fq.if_valid & not_full & ~fq.flush;
    assign pop       = not_empty & fq.id_ready & ~fq.flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry data is never cleared; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= {fq.if_pc, fq.if_inst};
        end
    end

    assign fq.if_ready  = not_full;
    assign fq.pc_stall  = ~not_full;
    assign fq.id_valid  = not_empty;
    assign fq.id_pc     = not_empty ? mem_q[rd_ptr_q][63:32] : 32'h0;
    assign fq.id_inst   = not_empty ? mem_q[rd_ptr_q][31:0]  : 32'h0;
    assign fq.occupancy = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: inputs change 1 time unit after each rising
// edge and outputs are sampled at that point, away from the active edge.
module tb_fetch_queue;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    fetch_queue_if #(.DEPTH(4)) fq ();

    fetch_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        fq.if_valid = v;
        fq.if_pc    = pc;
        fq.if_inst  = 32'hA000_0000 | pc;
        fq.id_ready = rdy;
        fq.flush    = fl;
    endtask

    // Every pushed instruction word is 0xA000_0000 | pc, so the head is fully
    // described by its PC; an empty queue must show zeros.
    task automatic chk_state(input string tag, input int occ, input logic [31:0] pc);
        logic [31:0] epc;
        logic [31:0] einst;
        epc   = (occ == 0) ? 32'h0 : pc;
        einst = (occ == 0) ? 32'h0 : (32'hA000_0000 | pc);
        check({tag, " occ"},      64'(fq.occupancy), 64'(occ));
        check({tag, " id_valid"}, 64'(fq.id_valid),  64'(occ != 0));
        check({tag, " id_pc"},    64'(fq.id_pc),     64'(epc));
        check({tag, " id_inst"},  64'(fq.id_inst),   64'(einst));
        check({tag, " if_ready"}, 64'(fq.if_ready),  64'(occ != 4));
        check({tag, " pc_stall"}, 64'(fq.pc_stall),  64'(occ == 4));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        chk_state("reset", 0, 32'h0);

        // Back-to-back push/pop: head trails the input by one cycle
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'(i * 4), 1'b1, 1'b0);
            cyc();
            chk_state($sformatf("stream%0d", i), 1, 32'(i * 4));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc();
        chk_state("stream_drain", 0, 32'h0);
        cyc();
        chk_state("idle_ready", 0, 32'h0);

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(i * 4), 1'b0, 1'b0);
            cyc();
            chk_state($sformatf("fill%0d", i), i + 1, 32'h00);
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        cyc();
        chk_state("full_reject", 4, 32'h00);
        drive(1'b1, 32'h10, 1'b1, 1'b0);
        cyc();
        chk_state("full_pop", 3, 32'h04);
        cyc();
        chk_state("late_accept", 3, 32'h08);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc();
        chk_state("drain_0c", 2, 32'h0C);
        cyc();
        chk_state("drain_10", 1, 32'h10);
        cyc();
        chk_state("drain_empty", 0, 32'h0);

        // Wrap-around
        drive(1'b1, 32'h20, 1'b0, 1'b0); cyc(); chk_state("wrap_f1", 1, 32'h20);
        drive(1'b1, 32'h24, 1'b0, 1'b0); cyc(); chk_state("wrap_f2", 2, 32'h20);
        drive(1'b1, 32'h28, 1'b0, 1'b0); cyc(); chk_state("wrap_f3", 3, 32'h20);
        drive(1'b0, 32'h0, 1'b1, 1'b0);  cyc(); chk_state("wrap_p1", 2, 32'h24);
        cyc();                                  chk_state("wrap_p2", 1, 32'h28);
        drive(1'b1, 32'h100, 1'b0, 1'b0); cyc(); chk_state("wrap_n1", 2, 32'h28);
        drive(1'b1, 32'h104, 1'b0, 1'b0); cyc(); chk_state("wrap_n2", 3, 32'h28);
        drive(1'b1, 32'h108, 1'b0, 1'b0); cyc(); chk_state("wrap_n3", 4, 32'h28);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(); chk_state("wrap_d1", 3, 32'h100);
        cyc(); chk_state("wrap_d2", 2, 32'h104);
        cyc(); chk_state("wrap_d3", 1, 32'h108);
        cyc(); chk_state("wrap_d4", 0, 32'h0);

        // Flush with push and pop offered in the same cycle
        drive(1'b1, 32'h30, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h34, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h38, 1'b0, 1'b0); cyc(); chk_state("pre_flush", 3, 32'h30);
        drive(1'b1, 32'h3C, 1'b1, 1'b1); cyc(); chk_state("flush", 0, 32'h0);
        drive(1'b1, 32'h200, 1'b0, 1'b0); cyc(); chk_state("post_flush", 1, 32'h200);

        // Flush in the cycle the queue would become full
        drive(1'b1, 32'h204, 1'b0, 1'b0); cyc();
        drive(1'b1, 32'h208, 1'b0, 1'b0); cyc(); chk_state("pre_flush_full", 3, 32'h200);
        drive(1'b1, 32'h20C, 1'b0, 1'b1); cyc(); chk_state("flush_at_full", 0, 32'h0);

        // Reset while full with both sides active
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            cyc();
        end
        chk_state("pre_reset", 4, 32'h300);
        rst = 1'b1;
        drive(1'b1, 32'h310, 1'b1, 1'b0);
        cyc();
        rst = 1'b0;
        chk_state("mid_reset", 0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc();
        chk_state("post_reset", 0, 32'h0);

        // Steady push+pop at occupancy 2 across pointer wrap
        drive(1'b1, 32'h400, 1'b0, 1'b0); cyc(); chk_state("ss_f1", 1, 32'h400);
        drive(1'b1, 32'h404, 1'b0, 1'b0); cyc(); chk_state("ss_f2", 2, 32'h400);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h408 + 32'(k * 4), 1'b1, 1'b0);
            cyc();
            chk_state($sformatf("ss%0d", k), 2, 32'h404 + 32'(k * 4));
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(); chk_state("ss_d1", 1, 32'h42C);
        cyc(); chk_state("ss_d2", 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
